// File: rtl/reg_bus_interconnect.sv
// Command-frame FIFO feeding a single-outstanding register-bus master, with
// lowest-index response muxing and timeout / collision / overflow fault reporting.
`timescale 1ns/1ps
module reg_bus_interconnect #(
  parameter int N_TARGETS  = 4,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W+DATA_W-1:0]    frame,
  input  logic                        frame_valid,
  output logic [ADDR_W-1:0]           address,
  output logic [DATA_W-1:0]           data,
  output logic                        valid,
  input  logic [N_TARGETS-1:0]        ack,
  input  logic [N_TARGETS*DATA_W-1:0] resp_data,
  input  logic [N_TARGETS-1:0]        resp_valid,
  output logic [DATA_W-1:0]           data_out,
  output logic                        data_out_valid,
  output logic                        fault,
  output logic [1:0]                  fault_code,
  output logic [7:0]                  fault_count,
  output logic                        busy,
  output logic                        fifo_full
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TMR_W   = $clog2(TIMEOUT + 1);

  localparam logic [1:0] FC_TIMEOUT   = 2'b01;
  localparam logic [1:0] FC_COLLISION = 2'b10;
  localparam logic [1:0] FC_OVERFLOW  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [FRAME_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [TMR_W-1:0]   r_timer;

  logic [ADDR_W-1:0]  r_address;
  logic [DATA_W-1:0]  r_data;
  logic [DATA_W-1:0]  r_data_out;
  logic               r_data_out_valid;
  logic               r_fault;
  logic [1:0]         r_fault_code;
  logic [7:0]         r_fault_count;

  logic               w_empty, w_full, w_push, w_pop, w_overflow;
  logic               w_done, w_timeout, w_multi, w_collision, w_fault;
  logic               w_resp_hit;
  logic [DATA_W-1:0]  w_resp_sel;

  // ---------------------------------------------------------------- FIFO
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  // A full FIFO still accepts a frame when the FSM pops the head in the same cycle.
  assign w_push     = frame_valid && (!w_full || w_pop);
  assign w_overflow = frame_valid && w_full && !w_pop;

  // NOTE: storage has no reset; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= frame;
  end

  // NOTE: every flop is updated with non-blocking assignments so all state
  // advances together on the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (|ack) begin
          w_done      = 1'b1;
          w_state_nxt = S_GAP;
        end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_timer   <= '0;
      r_address <= '0;
      r_data    <= '0;
    end else begin
      r_timer <= (r_state == S_REQ) ? r_timer + TMR_W'(1) : '0;
      if (w_pop) {r_address, r_data} <= r_mem[r_rd_ptr];
    end
  end

  // ------------------------------------------------------- response path
  // Descending scan so the lowest-index acking target with resp_valid wins.
  always_comb begin
    w_resp_hit = 1'b0;
    w_resp_sel = '0;
    for (int i = N_TARGETS - 1; i >= 0; i--) begin
      if (ack[i] && resp_valid[i]) begin
        w_resp_hit = 1'b1;
        w_resp_sel = resp_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more acks are high.
  assign w_multi     = |(ack & (ack - N_TARGETS'(1)));
  assign w_collision = w_done && w_multi;
  assign w_fault     = w_overflow || w_collision || w_timeout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
      r_fault          <= 1'b0;
      r_fault_code     <= 2'b00;
      r_fault_count    <= 8'd0;
    end else begin
      r_data_out_valid <= w_done && w_resp_hit;
      if (w_done && w_resp_hit) r_data_out <= w_resp_sel;
      r_fault <= w_fault;
      if      (w_overflow)  r_fault_code <= FC_OVERFLOW;
      else if (w_collision) r_fault_code <= FC_COLLISION;
      else if (w_timeout)   r_fault_code <= FC_TIMEOUT;
      if (w_fault && (r_fault_count != 8'hFF)) r_fault_count <= r_fault_count + 8'd1;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign address        = r_address;
  assign data           = r_data;
  assign valid          = (r_state == S_REQ);
  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;
  assign fault          = r_fault;
  assign fault_code     = r_fault_code;
  assign fault_count    = r_fault_count;
  assign busy           = (r_state != S_IDLE) || !w_empty;
  assign fifo_full      = w_full;

endmodule

// File: tb/tb_reg_bus_interconnect.sv
// Self-checking bench for reg_bus_interconnect: directed latency/fault sequences,
// a response-mux vector table, and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_reg_bus_interconnect;

  localparam int NT = 4;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int FD = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW+DW-1:0]  frame;
  logic              frame_valid;
  logic [AW-1:0]     address;
  logic [DW-1:0]     data;
  logic              valid;
  logic [NT-1:0]     ack;
  logic [NT*DW-1:0]  resp_data;
  logic [NT-1:0]     resp_valid;
  logic [DW-1:0]     data_out;
  logic              data_out_valid;
  logic              fault;
  logic [1:0]        fault_code;
  logic [7:0]        fault_count;
  logic              busy;
  logic              fifo_full;

  int checks = 0;
  int errors = 0;

  // Expected persistent output state, maintained by the bench.
  logic [7:0]    g_fcnt = 8'd0;
  logic [1:0]    g_code = 2'b00;
  logic [DW-1:0] g_dout = '0;

  reg_bus_interconnect #(
    .N_TARGETS(NT), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid),
    .address(address), .data(data), .valid(valid),
    .ack(ack), .resp_data(resp_data), .resp_valid(resp_valid),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .fault(fault), .fault_code(fault_code), .fault_count(fault_count),
    .busy(busy), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  frm;
    logic [3:0]  a;
    logic [3:0]  rv;
    logic [15:0] rd;
    logic        dov;
    logic [3:0]  dout;
    logic        flt;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    frame_valid = 1'b0;
    ack         = '0;
    resp_valid  = '0;
    resp_data   = '0;
  endtask

  task automatic send_frame(input logic [7:0] f);
    frame       = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({name, " valid rises"}, valid, 1);
  endtask

  task automatic serve(input logic [7:0] exp_frm, input string name);
    wait_valid(name);
    check({name, " addr/data"}, {address, data}, exp_frm);
    ack = 4'b0001;
    tick();
    ack = '0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h2B, 4'b0100, 4'b0100, 16'h0A00, 1'b1, 4'hA, 1'b0, 2'b01};
    vecs[1] = '{8'hC6, 4'b0110, 4'b0110, 16'h0730, 1'b1, 4'h3, 1'b1, 2'b10};
    vecs[2] = '{8'h5E, 4'b0001, 4'b0000, 16'hFFFF, 1'b0, 4'h0, 1'b0, 2'b10};
    vecs[3] = '{8'h90, 4'b1000, 4'b1001, 16'h5009, 1'b1, 4'h5, 1'b0, 2'b10};
    vecs[4] = '{8'hF1, 4'b1111, 4'b1100, 16'h9EC1, 1'b1, 4'hE, 1'b1, 2'b10};
    vecs[5] = '{8'h07, 4'b0010, 4'b1101, 16'h4321, 1'b0, 4'h0, 1'b0, 2'b10};
    vecs[6] = '{8'hA4, 4'b0001, 4'b0001, 16'h000D, 1'b1, 4'hD, 1'b0, 2'b10};

    // Reset state
    rst = 1'b0;
    frame = '0;
    idle_inputs();
    repeat (3) tick();
    check("reset valid", valid, 0);
    check("reset outputs", {address, data, data_out, data_out_valid, fault, fault_code}, 0);
    check("reset count/busy/full", {fault_count, busy, fifo_full}, 0);
    rst = 1'b1;
    tick();

    // Single write: latency t+2, response pulse at t+5
    send_frame(8'h35);
    check("B valid t+1", valid, 0);
    check("B busy t+1", busy, 1);
    tick();
    check("B valid t+2", valid, 1);
    check("B address", address, 3);
    check("B data", data, 5);
    tick();
    check("B valid t+3", valid, 1);
    tick();
    check("B valid t+4", valid, 1);
    ack = 4'b0100; resp_valid = 4'b0100; resp_data = 16'h0A00;
    tick();
    idle_inputs();
    g_dout = 4'hA;
    check("B valid t+5", valid, 0);
    check("B dov t+5", data_out_valid, 1);
    check("B data_out", data_out, g_dout);
    check("B fault", fault, 0);
    tick();
    check("B dov one-shot", data_out_valid, 0);
    repeat (2) tick();
    check("B busy idle", busy, 0);
    check("B fault_count", fault_count, g_fcnt);

    // Timeout: valid held exactly TO cycles, then next frame at k+3
    send_frame(8'h7C);
    send_frame(8'h81);
    begin
      int n = 0;
      while (valid === 1'b1 && n < 40) begin
        n++;
        tick();
      end
      check("C valid high cycles", n, TO);
    end
    g_fcnt = g_fcnt + 8'd1;
    g_code = 2'b01;
    check("C fault pulse", fault, 1);
    check("C fault_code", fault_code, g_code);
    check("C fault_count", fault_count, g_fcnt);
    check("C no dov", data_out_valid, 0);
    tick();
    check("C gap valid", valid, 0);
    check("C fault one-shot", fault, 0);
    tick();
    check("C next valid k+3", valid, 1);
    check("C next addr/data", {address, data}, 8'h81);
    ack = 4'b0001;
    tick();
    ack = '0;
    check("C ack no-resp dov", data_out_valid, 0);
    check("C ack no fault", fault, 0);
    tick();

    // Response-mux / collision vector table
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].frm);
      wait_valid($sformatf("V%0d", i));
      check($sformatf("V%0d addr/data", i), {address, data}, vecs[i].frm);
      ack = vecs[i].a; resp_valid = vecs[i].rv; resp_data = vecs[i].rd;
      tick();
      idle_inputs();
      if (vecs[i].dov) g_dout = vecs[i].dout;
      if (vecs[i].flt) g_fcnt = g_fcnt + 8'd1;
      g_code = vecs[i].code;
      check($sformatf("V%0d valid drop", i), valid, 0);
      check($sformatf("V%0d dov", i), data_out_valid, vecs[i].dov);
      check($sformatf("V%0d data_out", i), data_out, g_dout);
      check($sformatf("V%0d fault", i), fault, vecs[i].flt);
      check($sformatf("V%0d fault_code", i), fault_code, g_code);
      check($sformatf("V%0d fault_count", i), fault_count, g_fcnt);
      tick();
      check($sformatf("V%0d one-shot", i), {data_out_valid, fault}, 2'b00);
    end

    // Overflow: 6 strobes, 1 in flight + 4 buffered + 1 dropped
    for (int i = 0; i < 6; i++) begin
      frame = 8'h10 + 8'(i);
      frame_valid = 1'b1;
      tick();
    end
    frame_valid = 1'b0;
    g_fcnt = g_fcnt + 8'd1;
    g_code = 2'b11;
    check("D overflow fault", fault, 1);
    check("D fault_code", fault_code, g_code);
    check("D fifo_full", fifo_full, 1);
    check("D fault_count", fault_count, g_fcnt);
    for (int j = 0; j < 5; j++) serve(8'h10 + 8'(j), $sformatf("D txn%0d", j));
    begin
      int extra = 0;
      for (int j = 0; j < 10; j++) begin
        if (valid === 1'b1) extra++;
        tick();
      end
      check("D no 6th txn", extra, 0);
    end
    check("D fault_count after", fault_count, g_fcnt);

    // Full FIFO accepts a frame in the same cycle as the IDLE pop
    for (int i = 0; i < 5; i++) begin
      frame = 8'h20 + 8'(i);
      frame_valid = 1'b1;
      tick();
    end
    frame_valid = 1'b0;
    check("E fifo_full", fifo_full, 1);
    check("E in flight", {address, data}, 8'h20);
    ack = 4'b0001;
    tick();
    ack = '0;
    check("E gap full", fifo_full, 1);
    tick();
    send_frame(8'h2F);
    check("E no overflow", fault, 0);
    check("E still full", fifo_full, 1);
    serve(8'h21, "E txn1");
    serve(8'h22, "E txn2");
    serve(8'h23, "E txn3");
    serve(8'h24, "E txn4");
    serve(8'h2F, "E txn5");
    check("E fault_count", fault_count, g_fcnt);

    // Randomized run against a transaction-level model
    begin
      logic [7:0]  q[$];
      int          outstanding = 0, vcnt = 0, delay = 0, cyc = 0, sent = 0;
      bit          in_txn = 0, exp_end = 0, exp_flt = 0, exp_dov = 0, found;
      logic [3:0]  a, rv, hit;
      logic [15:0] rd;
      while ((sent < 60 || outstanding > 0) && cyc < 6000) begin
        check("R dov", data_out_valid, exp_dov);
        check("R data_out", data_out, g_dout);
        check("R fault", fault, exp_flt);
        check("R fault_code", fault_code, g_code);
        check("R fault_count", fault_count, g_fcnt);
        if (exp_end) check("R valid drop", valid, 0);
        exp_dov = 0; exp_flt = 0; exp_end = 0;
        idle_inputs();
        if (valid === 1'b1 && !in_txn) begin
          check("R issue expected", q.size() > 0, 1);
          if (q.size() > 0) check("R addr/data", {address, data}, q.pop_front());
          in_txn = 1; vcnt = 0;
          delay = $urandom_range(0, TO + 3);
        end
        if (in_txn) begin
          check("R valid held", valid, 1);
          if (vcnt == delay && delay < TO) begin
            a  = 4'($urandom_range(1, 15));
            rv = 4'($urandom);
            rd = 16'($urandom);
            ack = a; resp_valid = rv; resp_data = rd;
            hit = a & rv;
            found = 0;
            for (int i = 0; i < NT; i++) begin
              if (hit[i] && !found) begin
                found = 1;
                g_dout = rd[i*DW +: DW];
              end
            end
            exp_dov = found;
            if ($countones(a) > 1) begin
              exp_flt = 1; g_code = 2'b10; g_fcnt = g_fcnt + 8'd1;
            end
            in_txn = 0; exp_end = 1; outstanding--;
          end else if (vcnt == TO - 1) begin
            exp_flt = 1; g_code = 2'b01; g_fcnt = g_fcnt + 8'd1;
            in_txn = 0; exp_end = 1; outstanding--;
          end
          vcnt++;
        end else if (valid === 1'b0) begin
          ack = 4'($urandom); resp_valid = 4'($urandom); resp_data = 16'($urandom);
        end
        if (sent < 60 && outstanding < FD && $urandom_range(0, 2) == 0) begin
          frame = 8'($urandom);
          frame_valid = 1'b1;
          q.push_back(frame);
          outstanding++; sent++;
        end
        tick();
        cyc++;
      end
      idle_inputs();
      check("R within budget", cyc < 6000, 1);
      check("R tail dov", data_out_valid, exp_dov);
      check("R tail fault", fault, exp_flt);
      check("R tail fault_count", fault_count, g_fcnt);
      repeat (4) tick();
      check("R drained busy", busy, 0);
    end

    // Saturation: continuous overflow with no acks drives far beyond 255 pulses
    frame_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      frame = 8'(i);
      tick();
    end
    frame_valid = 1'b0;
    check("S fault_count saturated", fault_count, 255);
    check("S fault_code overflow priority", fault_code, 2'b11);

    // Reset mid-REQ, then a late ack is ignored
    wait_valid("F");
    rst = 1'b0;
    tick();
    check("F valid", valid, 0);
    check("F outputs", {address, data, data_out, data_out_valid, fault, fault_code}, 0);
    check("F count/busy/full", {fault_count, busy, fifo_full}, 0);
    rst = 1'b1;
    ack = 4'b1111; resp_valid = 4'b1111; resp_data = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("F late ack %0d", i), {valid, data_out_valid, fault, fault_count}, 0);
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
